// File: rtl/gradient_xy_pipe.sv
// gradient_xy_pipe: 4-stage separable Prewitt/Sobel Gx/Gy engine with saturation and valid/ready stall.
module gradient_xy_pipe #(
    parameter int DATA_WIDTH  = 8,
    parameter int KERNEL_SIZE = 5,
    parameter int OUT_WIDTH   = 16
) (
    input  logic                                                      i_clk,
    input  logic                                                      i_reset,
    input  logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][DATA_WIDTH-1:0]   i_image_window,
    input  logic                                                      i_valid,
    input  logic                                                      i_start_of_frame,
    input  logic                                                      i_kernel_mode,
    output logic                                                      o_ready,
    output logic [2*OUT_WIDTH-1:0]                                    o_gx_gy_vector,
    output logic                                                      o_valid,
    output logic                                                      o_start_of_frame,
    output logic                                                      o_saturated,
    output logic [15:0]                                               o_sat_count,
    input  logic                                                      i_ready
);
    localparam int K  = KERNEL_SIZE;
    localparam int PW = DATA_WIDTH + 5;
    localparam int GW = DATA_WIDTH + 8;
    localparam int HI = 2 ** (OUT_WIDTH - 1) - 1;
    localparam int LO = -(2 ** (OUT_WIDTH - 1));

    if (K != 3 && K != 5) begin : g_bad_kernel
        $error("KERNEL_SIZE must be 3 or 5");
    end
    if (OUT_WIDTH < 8 || OUT_WIDTH > 16) begin : g_bad_out
        $error("OUT_WIDTH must be in 8..16");
    end

    function automatic int s_co(input logic m, input int i);
        if (K == 3) return (m && i == 1) ? 2 : 1;
        return m ? ((i == 2) ? 6 : (i == 0 || i == 4) ? 1 : 4) : 1;
    endfunction

    function automatic int d_co(input logic m, input int i);
        if (K == 3) return i - 1;
        return m ? ((i == 0) ? -1 : (i == 1) ? -2 : (i == 2) ? 0 : (i == 3) ? 2 : 1) : i - 2;
    endfunction

    function automatic logic [OUT_WIDTH:0] clip(input logic signed [GW-1:0] g);
        int v;
        v = int'(g);
        return (v > HI) ? {1'b1, OUT_WIDTH'(HI)} : (v < LO) ? {1'b1, OUT_WIDTH'(LO)} : {1'b0, OUT_WIDTH'(v)};
    endfunction

    logic                                     en, mode_q, beat_mode;
    logic                                     v1, sof1, m1, v2, sof2, m2, v3, sof3;
    logic [K-1:0][K-1:0][DATA_WIDTH-1:0]      win1;
    logic [K-1:0][PW-1:0]                     col_n, row_n, col2, row2;
    logic signed [GW-1:0]                     gx_n, gy_n, gx3, gy3;
    logic [OUT_WIDTH:0]                       cx, cy;

    assign en        = i_ready | ~o_valid;
    assign o_ready   = en;
    assign beat_mode = i_start_of_frame ? i_kernel_mode : mode_q;
    assign cx        = clip(gx3);
    assign cy        = clip(gy3);

    // col sums feed Gx (d across columns), row sums feed Gy (d across rows)
    always_comb begin
        col_n = '0;
        row_n = '0;
        for (int a = 0; a < K; a++)
            for (int b = 0; b < K; b++) begin
                col_n[a] += PW'(s_co(m1, b) * int'(win1[b][a]));
                row_n[a] += PW'(s_co(m1, b) * int'(win1[a][b]));
            end
    end

    always_comb begin
        gx_n = '0;
        gy_n = '0;
        for (int a = 0; a < K; a++) begin
            gx_n += GW'(d_co(m2, a) * int'(col2[a]));
            gy_n += GW'(d_co(m2, a) * int'(row2[a]));
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            mode_q           <= 1'b0;
            {v1, sof1, m1}   <= '0;
            {v2, sof2, m2}   <= '0;
            {v3, sof3}       <= '0;
            win1             <= '0;
            col2             <= '0;
            row2             <= '0;
            gx3              <= '0;
            gy3              <= '0;
            o_valid          <= 1'b0;
            o_start_of_frame <= 1'b0;
            o_saturated      <= 1'b0;
            o_gx_gy_vector   <= '0;
            o_sat_count      <= '0;
        end else begin
            if (en) begin
                if (i_valid & i_start_of_frame) mode_q <= i_kernel_mode;
                v1               <= i_valid;
                sof1             <= i_valid & i_start_of_frame;
                m1               <= beat_mode;
                win1             <= i_image_window;
                v2               <= v1;
                sof2             <= sof1;
                m2               <= m1;
                col2             <= col_n;
                row2             <= row_n;
                v3               <= v2;
                sof3             <= sof2;
                gx3              <= gx_n;
                gy3              <= gy_n;
                o_valid          <= v3;
                o_start_of_frame <= sof3;
                o_saturated      <= v3 & (cx[OUT_WIDTH] | cy[OUT_WIDTH]);
                o_gx_gy_vector   <= {cy[OUT_WIDTH-1:0], cx[OUT_WIDTH-1:0]};
            end
            if (o_valid & i_ready)
                o_sat_count <= o_start_of_frame ? 16'(o_saturated) :
                               (o_saturated & ~&o_sat_count) ? o_sat_count + 16'd1 : o_sat_count;
        end
    end
endmodule

// File: tb/tb_gradient_xy_pipe.sv
// tb_gradient_xy_pipe: directed vectors for the gradient pipe at OUT_WIDTH 16 and 12 side by side.
module tb_gradient_xy_pipe;
    localparam int K  = 5;
    localparam int DW = 8;
    typedef logic [K-1:0][K-1:0][DW-1:0] win_t;
    typedef struct {
        int pat;
        int val;
        bit sof;
        bit mode;
        int gx;
        int gy;
    } vec_t;

    logic        clk = 0, rst = 1, i_valid = 0, i_sof = 0, i_mode = 0, i_ready = 1;
    win_t        win = '0;
    logic        o_ready, o_valid, o_sof, o_sat;
    logic        r12, v12, sof12, sat12;
    logic [31:0] vec16;
    logic [23:0] vec12;
    logic [15:0] cnt16, cnt12;
    int          checks = 0, errors = 0, cnt_m = 0;
    vec_t        tab[10];
    vec_t        sq[$];

    always #5 clk = ~clk;

    gradient_xy_pipe #(.DATA_WIDTH(DW), .KERNEL_SIZE(K), .OUT_WIDTH(16)) dut (
        .i_clk(clk), .i_reset(rst), .i_image_window(win), .i_valid(i_valid),
        .i_start_of_frame(i_sof), .i_kernel_mode(i_mode), .o_ready(o_ready),
        .o_gx_gy_vector(vec16), .o_valid(o_valid), .o_start_of_frame(o_sof),
        .o_saturated(o_sat), .o_sat_count(cnt16), .i_ready(i_ready));

    gradient_xy_pipe #(.DATA_WIDTH(DW), .KERNEL_SIZE(K), .OUT_WIDTH(12)) dut12 (
        .i_clk(clk), .i_reset(rst), .i_image_window(win), .i_valid(i_valid),
        .i_start_of_frame(i_sof), .i_kernel_mode(i_mode), .o_ready(r12),
        .o_gx_gy_vector(vec12), .o_valid(v12), .o_start_of_frame(sof12),
        .o_saturated(sat12), .o_sat_count(cnt12), .i_ready(i_ready));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int clip12(input int v);
        return (v > 2047) ? 2047 : (v < -2048) ? -2048 : v;
    endfunction

    function automatic bit sat_of(input vec_t v);
        return clip12(v.gx) != v.gx || clip12(v.gy) != v.gy;
    endfunction

    function automatic void upd_cnt(input bit sof, input bit s);
        cnt_m = sof ? int'(s) : (s && cnt_m < 65535) ? cnt_m + 1 : cnt_m;
    endfunction

    function automatic win_t mk(input int pat, input int val);
        win_t w;
        w = '0;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                w[r][c] = DW'(pat == 0 ? (c < 2 ? 0 : c == 2 ? 100 : 255) :
                              pat == 1 ? (r >= 3 ? 255 : 0) :
                              pat == 2 ? 50 :
                              pat == 3 ? (c < 2 ? 255 : c == 2 ? 100 : 0) :
                              (r == 1 && c == 3) ? val : 0);
        return w;
    endfunction

    task automatic apply(input vec_t v);
        int k;
        @(negedge clk);
        win = mk(v.pat, v.val); i_sof = v.sof; i_mode = v.mode; i_valid = 1;
        @(negedge clk);
        i_valid = 0; i_sof = 0;
        k = 1;
        while (!o_valid && k < 8) begin
            @(negedge clk);
            k++;
        end
        chk("latency", k, 4);
        chk("o_valid", int'(o_valid), 1);
        chk("o_sof", int'(o_sof), int'(v.sof));
        chk("gx16", int'($signed(vec16[15:0])), v.gx);
        chk("gy16", int'($signed(vec16[31:16])), v.gy);
        chk("sat16", int'(o_sat), 0);
        chk("gx12", int'($signed(vec12[11:0])), clip12(v.gx));
        chk("gy12", int'($signed(vec12[23:12])), clip12(v.gy));
        chk("sat12", int'(sat12), int'(sat_of(v)));
        upd_cnt(v.sof, sat_of(v));
        @(negedge clk);
        chk("drain", int'(o_valid), 0);
        chk("cnt12", int'(cnt12), cnt_m);
        chk("cnt16", int'(cnt16), 0);
    endtask

    task automatic stream(input int lo, input int hi);
        int sent, got, n;
        logic [31:0] held;
        bit hold;
        sent = 0; got = 0; n = sq.size(); hold = 0; held = '0;
        for (int cyc = 0; cyc < 80 && got < n; cyc++) begin
            @(negedge clk);
            i_ready = !(cyc >= lo && cyc <= hi);
            if (sent < n) begin
                win = mk(sq[sent].pat, sq[sent].val); i_sof = sq[sent].sof;
                i_mode = sq[sent].mode; i_valid = 1;
            end else begin
                i_valid = 0; i_sof = 0;
            end
            #1;
            if (o_valid && !i_ready) chk("o_ready_stall", int'(o_ready), 0);
            if (hold && o_valid) chk("held_vector", int'(vec16), int'(held));
            hold = o_valid && !i_ready;
            held = vec16;
            if (o_valid && i_ready) begin
                if (got < n) begin
                    chk("s_gx", int'($signed(vec16[15:0])), sq[got].gx);
                    chk("s_gy", int'($signed(vec16[31:16])), sq[got].gy);
                    chk("s_sof", int'(o_sof), int'(sq[got].sof));
                    upd_cnt(sq[got].sof, sat_of(sq[got]));
                end
                got++;
            end
            if (i_valid && o_ready) sent++;
        end
        i_valid = 0; i_sof = 0; i_ready = 1;
        chk("stream_count", got, n);
        got = 0;
        repeat (6) begin
            @(negedge clk);
            if (o_valid) got++;
        end
        chk("stream_extra", got, 0);
        chk("stream_cnt12", int'(cnt12), cnt_m);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tab[0] = '{0, 0, 1, 0, 3825, 0};
        tab[1] = '{1, 0, 0, 1, 0, 3825};
        tab[2] = '{5, 10, 0, 1, 10, -10};
        tab[3] = '{1, 0, 1, 1, 0, 12240};
        tab[4] = '{0, 0, 0, 0, 12240, 0};
        tab[5] = '{3, 0, 0, 0, -12240, 0};
        tab[6] = '{5, 10, 0, 0, 80, -80};
        tab[7] = '{2, 0, 0, 0, 0, 0};
        tab[8] = '{3, 0, 1, 0, -3825, 0};
        tab[9] = '{1, 0, 0, 1, 0, 3825};

        repeat (3) @(negedge clk);
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_vector", int'(vec16), 0);
        chk("rst_cnt", int'(cnt12), 0);
        chk("rst_ready", int'(o_ready), 1);
        rst = 0;

        foreach (tab[i]) apply(tab[i]);

        sq.delete();
        for (int j = 0; j < 10; j++) sq.push_back('{5, j + 1, j == 0, 0, j + 1, -(j + 1)});
        stream(5, 8);

        sq.delete();
        sq.push_back('{5, 3, 0, 0, 3, -3});
        sq.push_back('{5, 4, 1, 1, 32, -32});
        sq.push_back('{5, 5, 0, 0, 40, -40});
        sq.push_back('{5, 6, 0, 1, 48, -48});
        stream(-1, -1);

        apply('{0, 0, 0, 0, 12240, 0});
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            win = mk(0, 0); i_valid = 1;
        end
        @(negedge clk);
        i_valid = 0; rst = 1;
        @(negedge clk);
        chk("mid_rst_valid", int'(o_valid), 0);
        chk("mid_rst_cnt", int'(cnt12), 0);
        chk("mid_rst_vector", int'(vec16), 0);
        rst = 0; cnt_m = 0;
        begin
            int seen;
            seen = 0;
            repeat (6) begin
                @(negedge clk);
                if (o_valid) seen++;
            end
            chk("rst_discard", seen, 0);
        end
        apply('{5, 7, 0, 1, 7, -7});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
